// File: rtl/vga_frame_output.sv
// VGA raster timing and pixel output stage: scan counters for the object logic,
// RRRGGGBB expansion, and sync/blank delayed to line up with the returning colour.
module vga_frame_output #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE_DLY = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        pixelEn,
   input  logic [7:0]  RGBIn,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hSync,
   output logic        vSync,
   output logic        blankN
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] X_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] Y_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } timing_t;

   localparam timing_t TM_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

   timing_t tm_raw;
   timing_t tm_pipe [PIPE_DLY];
   timing_t tm_dly;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pixelX       <= '0;
         pixelY       <= '0;
         startOfFrame <= 1'b0;
      end else begin
         startOfFrame <= 1'b0;
         if (pixelEn) begin
            if (pixelX == X_LAST) begin
               pixelX <= '0;
               if (pixelY == Y_LAST) begin
                  pixelY       <= '0;
                  startOfFrame <= 1'b1;
               end else begin
                  pixelY <= pixelY + 11'd1;
               end
            end else begin
               pixelX <= pixelX + 11'd1;
            end
         end
      end
   end

   always_comb begin
      tm_raw        = TM_IDLE;
      tm_raw.active = (pixelX < X_VIS) && (pixelY < Y_VIS);
      tm_raw.hs     = !((pixelX >= HS_START) && (pixelX < HS_END));
      tm_raw.vs     = !((pixelY >= VS_START) && (pixelY < VS_END));
   end

   // Free-running (not pixelEn-gated): it tracks the object/mux pipeline, which is clocked every clk.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < PIPE_DLY; i++) tm_pipe[i] <= TM_IDLE;
      end else begin
         tm_pipe[0] <= tm_raw;
         for (int i = 1; i < PIPE_DLY; i++) tm_pipe[i] <= tm_pipe[i-1];
      end
   end

   assign tm_dly = tm_pipe[PIPE_DLY-1];

   // Bit replication maps 0 -> 8'h00 and full scale -> 8'hFF for every channel width.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hSync  <= 1'b1;
         vSync  <= 1'b1;
         blankN <= 1'b0;
         red    <= '0;
         green  <= '0;
         blue   <= '0;
      end else begin
         hSync  <= tm_dly.hs;
         vSync  <= tm_dly.vs;
         blankN <= tm_dly.active;
         if (tm_dly.active) begin
            red   <= {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]};
            green <= {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]};
            blue  <= {4{RGBIn[1:0]}};
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
      end
   end
endmodule
